cdb_arbiter: RTL and testbench

//  Shares the NUM_CDB_INPUTS lanes of the common data bus between NUM_REQ functional-unit result ports.

---
 rtl/oops_structs.sv | 19 +
 rtl/cdb_arbiter_rr_multi_pick.sv | 47 ++++
 rtl/cdb_arbiter.sv | 77 +++++++
 tb/tb_cdb_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/oops_structs.sv
// Shared out-of-order core types: common data bus lanes and the requester index map.
package oops_structs;
    localparam int NUM_CDB_INPUTS = 2;
    localparam int ROB_IDX_LEN    = 4;
    localparam int XLEN           = 32;

    localparam int CDB_REQ_ALU = 0;
    localparam int CDB_REQ_CMP = 1;
    localparam int CDB_REQ_LSU = 2;
    localparam int CDB_REQ_MUL = 3;

    typedef struct packed {
        logic                   valid;
        logic [ROB_IDX_LEN-1:0] rob_dest;
        logic [XLEN-1:0]        data;
    } cdb_lane_t;

    typedef cdb_lane_t [NUM_CDB_INPUTS-1:0] common_data_bus_t;
endpackage

// File: rtl/cdb_arbiter_rr_multi_pick.sv
// Combinational round-robin picker: grants up to K of N requests, scanning from i_ptr,
// and reports which requester feeds each lane plus the pointer to resume from.
module rr_multi_pick #(
    parameter int N = 4,
    parameter int K = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(K + 1),
    localparam int LW = (K > 1) ? $clog2(K) : 1
) (
    input  logic [N-1:0]          i_req,
    input  logic [IW-1:0]         i_ptr,
    output logic [N-1:0]          o_gnt,
    output logic [K-1:0][IW-1:0]  o_sel_idx,
    output logic [K-1:0]          o_sel_vld,
    output logic [CW-1:0]         o_cnt,
    output logic [IW-1:0]         o_nxt_ptr
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    always_comb begin
        o_gnt     = '0;
        o_sel_idx = '0;
        o_sel_vld = '0;
        o_cnt     = '0;
        o_nxt_ptr = i_ptr;
        w_sum     = '0;
        w_idx     = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_idx = w_sum[IW-1:0];
            // o_cnt doubles as the lane index the next winner lands on
            if (i_req[w_idx] && (o_cnt < CW'(K))) begin
                o_gnt[w_idx]                = 1'b1;
                o_sel_idx[o_cnt[LW-1:0]]    = w_idx;
                o_sel_vld[o_cnt[LW-1:0]]    = 1'b1;
                o_cnt                       = o_cnt + 1'b1;
                o_nxt_ptr = (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: rotating-priority grant of result ports onto the registered
// CDB lanes, one cycle of latency, with flush discarding the pending broadcast.
module cdb_arbiter
    import oops_structs::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = XLEN,
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int GW     = $clog2(NUM_CDB_INPUTS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  fls_i,
    input  logic [NUM_REQ-1:0]                    req_vld_i,
    output logic [NUM_REQ-1:0]                    req_rdy_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]         req_data_i,
    input  logic [NUM_REQ-1:0][ROB_IDX_LEN-1:0]   req_rob_i,
    output common_data_bus_t                      common_data_bus_o,
    output logic [GW-1:0]                         grant_cnt_o
);

    logic [NUM_REQ-1:0]                   w_req;
    logic [NUM_REQ-1:0]                   w_gnt;
    logic [NUM_CDB_INPUTS-1:0][PW-1:0]    w_sel_idx;
    logic [NUM_CDB_INPUTS-1:0]            w_sel_vld;
    logic [GW-1:0]                        w_cnt;
    logic [PW-1:0]                        w_nxt_ptr;
    common_data_bus_t                     w_bus_nxt;

    common_data_bus_t                     r_bus;
    logic [GW-1:0]                        r_cnt;
    logic [PW-1:0]                        r_ptr;

    // Masking requests under reset/flush yields no grants, so lanes clear and the pointer holds.
    assign w_req = (rst || fls_i) ? '0 : req_vld_i;

    rr_multi_pick #(
        .N (NUM_REQ),
        .K (NUM_CDB_INPUTS)
    ) u_pick (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_sel_idx (w_sel_idx),
        .o_sel_vld (w_sel_vld),
        .o_cnt     (w_cnt),
        .o_nxt_ptr (w_nxt_ptr)
    );

    always_comb begin
        w_bus_nxt = '0;
        for (int k = 0; k < NUM_CDB_INPUTS; k++) begin
            if (w_sel_vld[k]) begin
                w_bus_nxt[k].valid    = 1'b1;
                w_bus_nxt[k].rob_dest = req_rob_i[w_sel_idx[k]];
                w_bus_nxt[k].data     = req_data_i[w_sel_idx[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus <= '0;
            r_cnt <= '0;
            r_ptr <= '0;
        end else begin
            r_bus <= w_bus_nxt;
            r_cnt <= w_cnt;
            r_ptr <= w_nxt_ptr;
        end
    end

    assign req_rdy_o         = w_gnt;
    assign common_data_bus_o = r_bus;
    assign grant_cnt_o       = r_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based round-robin model checked every cycle, plus literal checks.
module tb_cdb_arbiter;
    import oops_structs::*;

    localparam int NREQ = 4;
    localparam int NCDB = NUM_CDB_INPUTS;

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               fls;
    logic [NREQ-1:0]                    vld;
    logic [NREQ-1:0]                    rdy;
    logic [NREQ-1:0][31:0]              data;
    logic [NREQ-1:0][ROB_IDX_LEN-1:0]   rob;
    common_data_bus_t                   bus;
    logic [1:0]                         gcnt;

    cdb_arbiter #(.NUM_REQ(NREQ), .WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .fls_i             (fls),
        .req_vld_i         (vld),
        .req_rdy_o         (rdy),
        .req_data_i        (data),
        .req_rob_i         (rob),
        .common_data_bus_o (bus),
        .grant_cnt_o       (gcnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic cdb_lane_t lane(input logic v, input logic [ROB_IDX_LEN-1:0] r,
                                       input logic [31:0] d);
        cdb_lane_t l;
        l.valid = v; l.rob_dest = r; l.data = d;
        return l;
    endfunction

    // Winners: requesters in rotated order starting at p, first NCDB of those asking.
    function automatic logic [NREQ-1:0] win_mask(input logic [NREQ-1:0] v, input int p);
        int order[$];
        logic [NREQ-1:0] m = '0;
        for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) order.push_back((p + k) % NREQ);
        for (int k = 0; k < order.size() && k < NCDB; k++) m[order[k]] = 1'b1;
        return m;
    endfunction

    int          m_ptr = 0;
    bit          m_ok  = 0;
    cdb_lane_t   exp_bus [NCDB];
    int          exp_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCDB; k++) exp_bus[k] = '0;
            exp_cnt = 0;
            m_ptr   = 0;
            m_ok    = 1;
        end else if (m_ok) begin
            logic [NREQ-1:0] m;
            int n, last;
            m = fls ? '0 : win_mask(vld, m_ptr);
            n = 0; last = -1;
            for (int k = 0; k < NCDB; k++) exp_bus[k] = '0;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (m[j]) begin
                    exp_bus[n] = lane(1'b1, rob[j], data[j]);
                    n++;
                    last = j;
                end
            end
            exp_cnt = n;
            if (n > 0) m_ptr = (last + 1) % NREQ;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            logic [NREQ-1:0] er;
            er = (rst || fls) ? '0 : win_mask(vld, m_ptr);
            check("model_rdy", 64'(rdy), 64'(er));
            check("model_cnt", 64'(gcnt), 64'(exp_cnt));
            for (int k = 0; k < NCDB; k++)
                check($sformatf("model_lane%0d", k), 64'(bus[k]), 64'(exp_bus[k]));
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    logic [NREQ-1:0] pat_v [12] = '{4'b1111, 4'b0001, 4'b1010, 4'b0000, 4'b0111, 4'b1100,
                                    4'b1111, 4'b0010, 4'b1011, 4'b1111, 4'b0101, 4'b1000};
    bit              pat_f [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        rst = 1'b1; fls = 1'b0; vld = '0;
        for (int i = 0; i < NREQ; i++) begin
            data[i] = 32'h100 + 32'(i);
            rob[i]  = ROB_IDX_LEN'(5 + i);
        end
        repeat (2) drive_edge();

        // 1: idle after reset
        rst = 1'b0; vld = '0;
        @(negedge clk);
        check("t1_rdy", 64'(rdy), 64'b0000);
        check("t1_bus", 64'(bus), 64'(0));
        check("t1_cnt", 64'(gcnt), 64'd0);

        // 2/3: all requesting from ptr 0
        drive_edge(); vld = 4'b1111;
        @(negedge clk);
        check("t2_rdy", 64'(rdy), 64'b0011);
        drive_edge();
        @(negedge clk);
        check("t2_lane0", 64'(bus[0]), 64'(lane(1'b1, 4'd5, 32'h100)));
        check("t2_lane1", 64'(bus[1]), 64'(lane(1'b1, 4'd6, 32'h101)));
        check("t2_cnt", 64'(gcnt), 64'd2);
        check("t3_rdy2", 64'(rdy), 64'b1100);
        drive_edge();
        @(negedge clk);
        check("t3_rdy3", 64'(rdy), 64'b0011);
        check("t3_lane0", 64'(bus[0]), 64'(lane(1'b1, 4'd7, 32'h102)));
        check("t3_lane1", 64'(bus[1]), 64'(lane(1'b1, 4'd8, 32'h103)));

        // 6: single request (ptr 2 now)
        drive_edge(); vld = 4'b0100; data[2] = 32'hDEADBEEF; rob[2] = 4'd3;
        @(negedge clk);
        check("t6_rdy", 64'(rdy), 64'b0100);

        // 4: wrap-around from ptr 3
        drive_edge(); vld = 4'b1001;
        @(negedge clk);
        check("t6_lane0", 64'(bus[0]), 64'(lane(1'b1, 4'd3, 32'hDEADBEEF)));
        check("t6_lane1", 64'(bus[1]), 64'(0));
        check("t6_cnt", 64'(gcnt), 64'd1);
        check("t4_rdy", 64'(rdy), 64'b1001);

        // 5: flush with ptr 1
        drive_edge(); vld = 4'b0110; fls = 1'b1;
        @(negedge clk);
        check("t4_lane0", 64'(bus[0]), 64'(lane(1'b1, 4'd8, 32'h103)));
        check("t4_lane1", 64'(bus[1]), 64'(lane(1'b1, 4'd5, 32'h100)));
        check("t5_rdy_fls", 64'(rdy), 64'b0000);
        drive_edge(); fls = 1'b0;
        @(negedge clk);
        check("t5_bus_clr", 64'(bus), 64'(0));
        check("t5_cnt_clr", 64'(gcnt), 64'd0);
        check("t5_regrant", 64'(rdy), 64'b0110);

        // mid-stream reset
        drive_edge(); vld = 4'b1111; rst = 1'b1;
        @(negedge clk);
        check("rst_lane0", 64'(bus[0]), 64'(lane(1'b1, 4'd6, 32'h101)));
        check("rst_lane1", 64'(bus[1]), 64'(lane(1'b1, 4'd3, 32'hDEADBEEF)));
        check("rst_rdy", 64'(rdy), 64'b0000);
        drive_edge(); rst = 1'b0;
        @(negedge clk);
        check("rst_bus_clr", 64'(bus), 64'(0));
        check("rst_ptr0", 64'(rdy), 64'b0011);

        // mixed patterns, checked by the model
        for (int i = 0; i < 12; i++) begin
            drive_edge();
            vld = pat_v[i]; fls = pat_f[i];
            data[i % NREQ] = 32'hA000 + 32'(i);
            rob[i % NREQ]  = ROB_IDX_LEN'(i);
        end
        drive_edge(); vld = '0; fls = 1'b0;
        repeat (2) drive_edge();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
